pulse_sequencer: RTL and testbench
==================================

# pulse_sequencer

Symbol-table sequencer for the pulse transmitter. It plays a programmed list of (level, duration) symbols, optionally repeated, and drives the enable of the 50% duty-cycle carrier generator so that mark symbols are carrier-modulated. The final modulated pulse stream leaves the transmitter from this block. It sits between the peripheral register interface and the carrier generator.

## Interface
- TIMER_WIDTH, 16, width of symbol duration field and of the carrier generator's duration
- NUM_SYMBOLS, 8, table depth; power of two, ≥2; ADDR_W = $clog2(NUM_SYMBOLS)
- clk  in  1  system clock
- sys_rst  in  1  reset, asynchronous, active-high
- cfg_we  in  1  table write strobe
- cfg_addr  in  ADDR_W  table entry written
- cfg_wdata  in  TIMER_WIDTH+1  bit TIMER_WIDTH = level; bits TIMER_WIDTH-1:0 = duration D
- seq_last  in  ADDR_W  index of last symbol played (sequence length − 1)
- loop_count  in  8  extra repetitions of the whole sequence; 0 = play once
- mod_en  in  1  1 = mark symbols gated by carrier; 0 = raw levels
- idle_level  in  1  pulse_out level when not running
- start  in  1  single-cycle start request
- stop  in  1  single-cycle abort request
- carrier_in  in  1  output of the carrier generator
- carrier_en  out  1  enable to the carrier generator
- pulse_out  out  1  transmitted signal
- busy  out  1  sequence in progress
- done  out  1  one-cycle completion pulse
- sym_idx  out  ADDR_W  index of the symbol currently playing

## Operation
- Table: NUM_SYMBOLS registers of TIMER_WIDTH+1 bits, cleared by reset. A write lands at the clock edge with cfg_we=1. Writes are allowed at any time; an entry is read only when its symbol is loaded.
- States: IDLE, RUN, DONE.
- IDLE: on start=1 and stop=0, latch seq_last and loop_count (loops_left), load entry 0 (counter ← D, level ← bit), set sym_idx ← 0, go to RUN. start is ignored in RUN/DONE.
- RUN, counter ≠ 0: counter decrements.
- RUN, counter = 0, sym_idx < latched seq_last: load entry sym_idx+1.
- RUN, counter = 0, sym_idx = seq_last, loops_left ≠ 0: loops_left decrements, load entry 0, sym_idx ← 0.
- RUN, counter = 0, sym_idx = seq_last, loops_left = 0: go to DONE.
- DONE: one cycle, then IDLE.
- stop=1 in RUN or DONE: go to IDLE next edge with no done pulse. stop wins over a simultaneous start.
- Each symbol lasts exactly D+1 cycles. Symbols are back-to-back with no gap cycle. D=0 gives a 1-cycle symbol.
- The counter is TIMER_WIDTH bits and never wraps: a reload always occurs at 0.
- carrier_en (registered) = 1 only in RUN with current level=1 and mod_en=1. The carrier therefore restarts phase (output low) at every mark.
- pulse_out (combinational from registered state) = idle_level in IDLE/DONE. In RUN it is level & carrier_in if mod_en, else level.
- busy = 1 in RUN only. done = 1 in DONE only.
- mod_en and idle_level are live, not latched.

## Timing
- Reset values: state IDLE, busy 0, done 0, carrier_en 0, sym_idx 0, counter 0, level 0, loops_left 0, table all 0. pulse_out = idle_level.
- Reset asserted mid-sequence: all of the above take effect immediately (asynchronously). No done pulse.
- Start accepted at edge T: busy, sym_idx, level and carrier_en valid from T+1.
- Total RUN length = (loop_count+1) × Σ(D_i+1) over i = 0..seq_last.
- done is high in the cycle after the last RUN cycle. busy is 0 in that same cycle.
- A new start is accepted in the cycle after done, once the block is back in IDLE.

## Test plan
- Table {1:4, 0:2}, seq_last=1, loop_count=0, mod_en=0, idle_level=0. Pulse start → pulse_out high 5 cycles, low 3 cycles, done on cycle 9 after start, busy high for exactly 8 cycles.
- Same table with loop_count=2 → pattern repeats 3 times (24 RUN cycles). sym_idx sequence 0,1,0,1,0,1. Single done pulse.
- mod_en=1 with carrier duration 1, symbol {1:7} → carrier_en high 8 cycles. pulse_out shows carrier toggling every 2 cycles, starting low.
- stop asserted 3 cycles into the RUN → IDLE next cycle, busy 0, no done, pulse_out = idle_level=1. start+stop in the same IDLE cycle → stays IDLE.
- D=0 on all 8 entries, seq_last=7 → 8 one-cycle symbols with no gaps. Rewriting entry 5 while sym_idx=2 → new value is used.
- Assert sys_rst mid-symbol → outputs reset immediately, table reads back zero, and a subsequent start plays 1-cycle low symbols.

Source files
------------

// File: rtl/pulse_sequencer.sv
// Symbol-table pulse sequencer: plays (level, duration) symbols, optionally looped,
// and gates mark symbols with the external carrier generator.
module pulse_sequencer #(
    parameter int unsigned TIMER_WIDTH = 16,
    parameter int unsigned NUM_SYMBOLS = 8,
    localparam int unsigned ADDR_W = $clog2(NUM_SYMBOLS)
) (
    input  logic                   clk,
    input  logic                   sys_rst,
    input  logic                   cfg_we,
    input  logic [ADDR_W-1:0]      cfg_addr,
    input  logic [TIMER_WIDTH:0]   cfg_wdata,
    input  logic [ADDR_W-1:0]      seq_last,
    input  logic [7:0]             loop_count,
    input  logic                   mod_en,
    input  logic                   idle_level,
    input  logic                   start,
    input  logic                   stop,
    input  logic                   carrier_in,
    output logic                   carrier_en,
    output logic                   pulse_out,
    output logic                   busy,
    output logic                   done,
    output logic [ADDR_W-1:0]      sym_idx
);

    typedef enum logic [1:0] {StIdle, StRun, StDone} state_e;

    localparam logic [ADDR_W-1:0]      IdxOne   = 1;
    localparam logic [TIMER_WIDTH-1:0] TimerOne = 1;

    state_e                   state_q, state_d;
    logic [TIMER_WIDTH-1:0]   counter_q, counter_d;
    logic                     level_q, level_d;
    logic [ADDR_W-1:0]        sym_idx_q, sym_idx_d;
    logic [ADDR_W-1:0]        seq_last_q, seq_last_d;
    logic [7:0]               loops_left_q, loops_left_d;
    logic                     carrier_en_q, carrier_en_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic [TIMER_WIDTH:0]     table_q [NUM_SYMBOLS];
    logic [TIMER_WIDTH:0]     table_d [NUM_SYMBOLS];

    logic                     load;
    logic [ADDR_W-1:0]        load_idx;

    always_comb begin
        table_d = table_q;
        if (cfg_we) begin
            table_d[cfg_addr] = cfg_wdata;
        end
    end

    always_comb begin
        state_d      = state_q;
        counter_d    = counter_q;
        level_d      = level_q;
        sym_idx_d    = sym_idx_q;
        seq_last_d   = seq_last_q;
        loops_left_d = loops_left_q;
        load         = 1'b0;
        load_idx     = '0;

        unique case (state_q)
            StIdle: begin
                if (start && !stop) begin
                    state_d      = StRun;
                    seq_last_d   = seq_last;
                    loops_left_d = loop_count;
                    load         = 1'b1;
                end
            end
            StRun: begin
                if (stop) begin
                    state_d = StIdle;
                end else if (counter_q != '0) begin
                    counter_d = counter_q - TimerOne;
                end else if (sym_idx_q < seq_last_q) begin
                    load     = 1'b1;
                    load_idx = sym_idx_q + IdxOne;
                end else if (loops_left_q != 8'd0) begin
                    loops_left_d = loops_left_q - 8'd1;
                    load         = 1'b1;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase

        // The table entry is sampled only at the moment its symbol starts.
        if (load) begin
            counter_d = table_q[load_idx][TIMER_WIDTH-1:0];
            level_d   = table_q[load_idx][TIMER_WIDTH];
            sym_idx_d = load_idx;
        end

        carrier_en_d = (state_d == StRun) && level_d && mod_en;
        busy_d       = (state_d == StRun);
        done_d       = (state_d == StDone);
    end

    always_ff @(posedge clk or posedge sys_rst) begin
        if (sys_rst) begin
            state_q      <= StIdle;
            counter_q    <= '0;
            level_q      <= 1'b0;
            sym_idx_q    <= '0;
            seq_last_q   <= '0;
            loops_left_q <= 8'd0;
            carrier_en_q <= 1'b0;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
            for (int i = 0; i < NUM_SYMBOLS; i++) begin
                table_q[i] <= '0;
            end
        end else begin
            state_q      <= state_d;
            counter_q    <= counter_d;
            level_q      <= level_d;
            sym_idx_q    <= sym_idx_d;
            seq_last_q   <= seq_last_d;
            loops_left_q <= loops_left_d;
            carrier_en_q <= carrier_en_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
            table_q      <= table_d;
        end
    end

    // Carrier gating is combinational so the output follows carrier_in without delay.
    always_comb begin
        if (state_q == StRun) begin
            pulse_out = mod_en ? (level_q & carrier_in) : level_q;
        end else begin
            pulse_out = idle_level;
        end
    end

    assign carrier_en = carrier_en_q;
    assign busy       = busy_q;
    assign done       = done_q;
    assign sym_idx    = sym_idx_q;

endmodule

// File: tb/tb_pulse_sequencer.sv
// Self-checking bench for pulse_sequencer: directed scenarios plus randomized tables,
// compared against a per-cycle trace expanded from the symbol list.
module tb_pulse_sequencer;

    localparam int TW = 16;
    localparam int NS = 8;
    localparam int AW = 3;

    logic          clk;
    logic          sys_rst;
    logic          cfg_we;
    logic [AW-1:0] cfg_addr;
    logic [TW:0]   cfg_wdata;
    logic [AW-1:0] seq_last;
    logic [7:0]    loop_count;
    logic          mod_en;
    logic          idle_level;
    logic          start;
    logic          stop;
    logic          carrier_in;
    logic          carrier_en;
    logic          pulse_out;
    logic          busy;
    logic          done;
    logic [AW-1:0] sym_idx;

    pulse_sequencer #(
        .TIMER_WIDTH(TW),
        .NUM_SYMBOLS(NS)
    ) dut (
        .clk       (clk),
        .sys_rst   (sys_rst),
        .cfg_we    (cfg_we),
        .cfg_addr  (cfg_addr),
        .cfg_wdata (cfg_wdata),
        .seq_last  (seq_last),
        .loop_count(loop_count),
        .mod_en    (mod_en),
        .idle_level(idle_level),
        .start     (start),
        .stop      (stop),
        .carrier_in(carrier_in),
        .carrier_en(carrier_en),
        .pulse_out (pulse_out),
        .busy      (busy),
        .done      (done),
        .sym_idx   (sym_idx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Simple 50% carrier generator: low on enable, toggles every gen_dur+1 cycles.
    int   gen_dur = 1;
    int   gen_cnt = 0;
    logic carr_gen = 1'b0;
    logic carr_rand = 1'b0;
    bit   use_gen = 1'b0;

    always @(posedge clk) begin
        if (!carrier_en) begin
            gen_cnt  <= 0;
            carr_gen <= 1'b0;
        end else if (gen_cnt == gen_dur) begin
            gen_cnt  <= 0;
            carr_gen <= ~carr_gen;
        end else begin
            gen_cnt <= gen_cnt + 1;
        end
    end

    assign carrier_in = use_gen ? carr_gen : carr_rand;

    int checks = 0;
    int failures = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at t=%0t", tag, got, exp, $time);
        end
    endtask

    // Reference symbol table and expanded per-cycle trace.
    bit m_lvl [NS];
    int m_dur [NS];
    bit q_lvl [$];
    int q_idx [$];

    task automatic write_entry(input int addr, input bit lvl, input int dur);
        cfg_we    = 1'b1;
        cfg_addr  = AW'(addr);
        cfg_wdata = {lvl, TW'(dur)};
        @(posedge clk);
        #1 cfg_we = 1'b0;
        m_lvl[addr] = lvl;
        m_dur[addr] = dur;
    endtask

    task automatic build_trace(input int last, input int loops);
        q_lvl.delete();
        q_idx.delete();
        for (int r = 0; r <= loops; r++) begin
            for (int i = 0; i <= last; i++) begin
                for (int k = 0; k <= m_dur[i]; k++) begin
                    q_lvl.push_back(m_lvl[i]);
                    q_idx.push_back(i);
                end
            end
        end
    endtask

    // Plays the prepared trace; caller is positioned just after a rising edge.
    task automatic play(input int last, input int loops, input bit rnd_noise,
                        input int wr_cycle, input int wr_addr, input logic [TW:0] wr_data);
        int pos;
        bit lvl;
        bit exp_p;
        seq_last   = AW'(last);
        loop_count = 8'(loops);
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        pos = 0;
        for (int n = 0; n < q_lvl.size(); n++) begin
            lvl = q_lvl[n];
            if (!use_gen) carr_rand = 1'($urandom_range(0, 1));
            if (rnd_noise) begin
                // Inputs that must be ignored or already latched while running.
                start      = 1'($urandom_range(0, 1));
                seq_last   = AW'($urandom);
                loop_count = 8'($urandom);
            end
            if (n == wr_cycle) begin
                cfg_we    = 1'b1;
                cfg_addr  = AW'(wr_addr);
                cfg_wdata = wr_data;
            end
            @(negedge clk);
            if (!mod_en) exp_p = lvl;
            else if (use_gen) exp_p = lvl & 1'((pos / (gen_dur + 1)) % 2);
            else exp_p = lvl & carr_rand;
            check_eq("run_busy", 32'(busy), 32'd1);
            check_eq("run_done", 32'(done), 32'd0);
            check_eq("run_sym_idx", 32'(sym_idx), 32'(q_idx[n]));
            check_eq("run_carrier_en", 32'(carrier_en), 32'(lvl & mod_en));
            check_eq("run_pulse_out", 32'(pulse_out), 32'(exp_p));
            pos = lvl ? pos + 1 : 0;
            @(posedge clk);
            #1 cfg_we = 1'b0;
            start = 1'b0;
        end
        start = rnd_noise ? 1'($urandom_range(0, 1)) : 1'b0;
        @(negedge clk);
        check_eq("done_pulse", 32'(done), 32'd1);
        check_eq("done_busy", 32'(busy), 32'd0);
        check_eq("done_carrier_en", 32'(carrier_en), 32'd0);
        check_eq("done_pulse_out", 32'(pulse_out), 32'(idle_level));
        @(posedge clk);
        #1 start = 1'b0;
        @(negedge clk);
        check_eq("post_done", 32'(done), 32'd0);
        check_eq("post_busy", 32'(busy), 32'd0);
        check_eq("post_pulse_out", 32'(pulse_out), 32'(idle_level));
        @(posedge clk);
        #1;
    endtask

    initial begin
        sys_rst    = 1'b1;
        cfg_we     = 1'b0;
        cfg_addr   = '0;
        cfg_wdata  = '0;
        seq_last   = '0;
        loop_count = 8'd0;
        mod_en     = 1'b0;
        idle_level = 1'b0;
        start      = 1'b0;
        stop       = 1'b0;
        for (int i = 0; i < NS; i++) begin
            m_lvl[i] = 1'b0;
            m_dur[i] = 0;
        end
        #1;
        check_eq("rst_busy", 32'(busy), 32'd0);
        check_eq("rst_done", 32'(done), 32'd0);
        check_eq("rst_carrier_en", 32'(carrier_en), 32'd0);
        check_eq("rst_sym_idx", 32'(sym_idx), 32'd0);
        check_eq("rst_pulse_out", 32'(pulse_out), 32'd0);
        @(posedge clk);
        @(posedge clk);
        #1 sys_rst = 1'b0;

        // Two-symbol table, played once and then looped three times.
        write_entry(0, 1'b1, 4);
        write_entry(1, 1'b0, 2);
        build_trace(1, 0);
        play(1, 0, 1'b0, -1, 0, '0);
        build_trace(1, 2);
        play(1, 2, 1'b0, -1, 0, '0);

        // Carrier-gated single mark.
        mod_en  = 1'b1;
        use_gen = 1'b1;
        write_entry(0, 1'b1, 7);
        build_trace(0, 0);
        play(0, 0, 1'b0, -1, 0, '0);
        use_gen = 1'b0;
        mod_en  = 1'b0;

        // Abort three cycles into RUN, then start+stop together in IDLE.
        write_entry(0, 1'b1, 4);
        idle_level = 1'b1;
        seq_last   = AW'(1);
        loop_count = 8'd0;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check_eq("pre_stop_busy", 32'(busy), 32'd1);
            @(posedge clk);
            #1;
        end
        stop = 1'b1;
        @(posedge clk);
        #1 stop = 1'b0;
        @(negedge clk);
        check_eq("stop_busy", 32'(busy), 32'd0);
        check_eq("stop_done", 32'(done), 32'd0);
        check_eq("stop_carrier_en", 32'(carrier_en), 32'd0);
        check_eq("stop_pulse_out", 32'(pulse_out), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("stop_no_done", 32'(done), 32'd0);
        @(posedge clk);
        #1 start = 1'b1;
        stop = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        stop = 1'b0;
        @(negedge clk);
        check_eq("start_stop_busy", 32'(busy), 32'd0);
        check_eq("start_stop_pulse_out", 32'(pulse_out), 32'd1);
        @(posedge clk);
        #1;
        @(negedge clk);
        check_eq("start_stop_done", 32'(done), 32'd0);
        @(posedge clk);
        #1 idle_level = 1'b0;

        // Eight one-cycle symbols; entry 5 rewritten while symbol 2 plays.
        for (int i = 0; i < NS; i++) write_entry(i, 1'(i & 1), 0);
        m_lvl[5] = 1'b1;
        m_dur[5] = 3;
        build_trace(7, 0);
        play(7, 0, 1'b0, 2, 5, {1'b1, 16'd3});

        // Asynchronous reset mid-symbol clears state and table.
        write_entry(0, 1'b1, 9);
        idle_level = 1'b1;
        seq_last   = AW'(0);
        loop_count = 8'd0;
        start      = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #3 sys_rst = 1'b1;
        #1;
        check_eq("arst_busy", 32'(busy), 32'd0);
        check_eq("arst_done", 32'(done), 32'd0);
        check_eq("arst_carrier_en", 32'(carrier_en), 32'd0);
        check_eq("arst_sym_idx", 32'(sym_idx), 32'd0);
        check_eq("arst_pulse_out", 32'(pulse_out), 32'd1);
        #2 sys_rst = 1'b0;
        for (int i = 0; i < NS; i++) begin
            m_lvl[i] = 1'b0;
            m_dur[i] = 0;
        end
        @(posedge clk);
        #1;
        build_trace(3, 0);
        play(3, 0, 1'b0, -1, 0, '0);

        // Randomized tables and run options.
        for (int it = 0; it < 20; it++) begin
            int last;
            int loops;
            for (int i = 0; i < NS; i++) begin
                write_entry(i, 1'($urandom_range(0, 1)), int'($urandom_range(0, 4)));
            end
            last       = int'($urandom_range(0, NS - 1));
            loops      = int'($urandom_range(0, 2));
            mod_en     = 1'($urandom_range(0, 1));
            idle_level = 1'($urandom_range(0, 1));
            use_gen    = mod_en & 1'($urandom_range(0, 1));
            build_trace(last, loops);
            play(last, loops, 1'b1, -1, 0, '0);
        end
        use_gen = 1'b0;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
